decoding_block: RTL and testbench

- Receive-side counterpart of the lane encoder. Takes one deserialized 132-bit (Gen3) or 66-bit (Gen2) symbol per lane.
- Checks and strips the sync header, then replays the payload on both lanes as one byte per enc_clk, tagged ordered-set or transport.
- Sits between the lane deserializers and the logical-layer receive path.
- Gen4 byte mode is a registered passthrough.

---
 rtl/decoding_block.sv | 231 +++++++++++++++++++++++
 tb/tb_decoding_block.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoding_block.sv
// decoding_block: receive-side lane decoder.
// Takes one deserialized symbol per lane (Gen3 128b/132b or Gen2 64b/66b),
// checks that the sync header is legal and the same on both lanes, strips it,
// and replays the payload one byte per enc_clk on both lanes. Gen4 byte mode
// is a one-cycle registered passthrough of lane_x_rx_enc[7:0].
//
// Ports:
//   enc_clk        clock, rising edge
//   rst            asynchronous, active-low reset
//   enable         synchronous run enable; 0 clears the block
//   gen_speed      0=Gen4 byte, 1=Gen3, 2=Gen2, 3=reserved (captures ignored)
//   sym_valid      strobe: lane_x_rx_enc holds a new symbol
//   lane_0_rx_enc  lane 0 encoded symbol (Gen2 uses [65:0])
//   lane_1_rx_enc  lane 1 encoded symbol
//   lane_0_rx      decoded lane 0 byte
//   lane_1_rx      decoded lane 1 byte
//   rx_valid       lane_x_rx valid this cycle
//   rx_type        1=transport, 0=ordered set
//   rx_sof         first byte of a symbol
//   hdr_err        pulse: symbol rejected for a bad header
//   overflow       pulse: symbol dropped, pending buffer full
module decoding_block #(
  parameter int NUM_BYTES_G3 = 16,
  parameter int NUM_BYTES_G2 = 8
) (
  input  logic         enc_clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [1:0]   gen_speed,
  input  logic         sym_valid,
  input  logic [131:0] lane_0_rx_enc,
  input  logic [131:0] lane_1_rx_enc,
  output logic [7:0]   lane_0_rx,
  output logic [7:0]   lane_1_rx,
  output logic         rx_valid,
  output logic         rx_type,
  output logic         rx_sof,
  output logic         hdr_err,
  output logic         overflow
);

  localparam int PW3 = 8 * NUM_BYTES_G3;
  localparam int PW2 = 8 * NUM_BYTES_G2;
  localparam int CW  = $clog2(NUM_BYTES_G3);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  logic [PW3-1:0]  act_pay0, act_pay1;
  logic [CW-1:0]   act_last;
  logic            act_type;

  logic [PW3-1:0]  pend_pay0, pend_pay1;
  logic [CW-1:0]   pend_last;
  logic            pend_type;
  logic            pend_full;

  // Decoded view of the symbol currently on the inputs.
  logic            hdr_ok;
  logic            in_type;
  logic [PW3-1:0]  in_pay0, in_pay1;
  logic [CW-1:0]   in_last;
  logic            capture, cap_ok, cap_bad;

  function automatic logic [7:0] byte_at(input logic [PW3-1:0] p, input logic [CW-1:0] k);
    return p[int'(k)*8 +: 8];
  endfunction

  always_comb begin
    hdr_ok  = 1'b0;
    in_type = 1'b0;
    in_pay0 = '0;
    in_pay1 = '0;
    in_last = '0;
    case (gen_speed)
      2'd1: begin
        hdr_ok  = (lane_0_rx_enc[3:0] == lane_1_rx_enc[3:0]) &&
                  ((lane_0_rx_enc[3:0] == 4'b0101) || (lane_0_rx_enc[3:0] == 4'b1010));
        in_type = (lane_0_rx_enc[3:0] == 4'b1010);
        in_pay0 = lane_0_rx_enc[4 +: PW3];
        in_pay1 = lane_1_rx_enc[4 +: PW3];
        in_last = CW'(NUM_BYTES_G3 - 1);
      end
      2'd2: begin
        hdr_ok  = (lane_0_rx_enc[1:0] == lane_1_rx_enc[1:0]) &&
                  ((lane_0_rx_enc[1:0] == 2'b01) || (lane_0_rx_enc[1:0] == 2'b10));
        in_type = (lane_0_rx_enc[1:0] == 2'b10);
        in_pay0[PW2-1:0] = lane_0_rx_enc[2 +: PW2];
        in_pay1[PW2-1:0] = lane_1_rx_enc[2 +: PW2];
        in_last = CW'(NUM_BYTES_G2 - 1);
      end
      default: ;
    endcase
    capture = enable && sym_valid && ((gen_speed == 2'd1) || (gen_speed == 2'd2));
    cap_ok  = capture && hdr_ok;
    cap_bad = capture && !hdr_ok;
  end

  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      act_pay0  <= '0;
      act_pay1  <= '0;
      act_last  <= '0;
      act_type  <= 1'b0;
      pend_pay0 <= '0;
      pend_pay1 <= '0;
      pend_last <= '0;
      pend_type <= 1'b0;
      pend_full <= 1'b0;
      lane_0_rx <= '0;
      lane_1_rx <= '0;
      rx_valid  <= 1'b0;
      rx_type   <= 1'b0;
      rx_sof    <= 1'b0;
      hdr_err   <= 1'b0;
      overflow  <= 1'b0;
    end else if (!enable) begin
      state     <= IDLE;
      cnt       <= '0;
      act_pay0  <= '0;
      act_pay1  <= '0;
      act_last  <= '0;
      act_type  <= 1'b0;
      pend_pay0 <= '0;
      pend_pay1 <= '0;
      pend_last <= '0;
      pend_type <= 1'b0;
      pend_full <= 1'b0;
      lane_0_rx <= '0;
      lane_1_rx <= '0;
      rx_valid  <= 1'b0;
      rx_type   <= 1'b0;
      rx_sof    <= 1'b0;
      hdr_err   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      // Defaults: idle output bus; later assignments override.
      hdr_err   <= cap_bad;
      overflow  <= 1'b0;
      lane_0_rx <= '0;
      lane_1_rx <= '0;
      rx_valid  <= 1'b0;
      rx_type   <= 1'b0;
      rx_sof    <= 1'b0;
      case (state)
        IDLE: begin
          if (cap_ok) begin
            // Byte 0 goes straight from the input so it appears one cycle
            // after the strobe; the buffer supplies the rest.
            act_pay0  <= in_pay0;
            act_pay1  <= in_pay1;
            act_last  <= in_last;
            act_type  <= in_type;
            cnt       <= '0;
            state     <= EMIT;
            lane_0_rx <= byte_at(in_pay0, '0);
            lane_1_rx <= byte_at(in_pay1, '0);
            rx_valid  <= 1'b1;
            rx_type   <= in_type;
            rx_sof    <= 1'b1;
          end else if (sym_valid && (gen_speed == 2'd0)) begin
            lane_0_rx <= lane_0_rx_enc[7:0];
            lane_1_rx <= lane_1_rx_enc[7:0];
            rx_valid  <= 1'b1;
            rx_sof    <= 1'b1;
          end
        end
        EMIT: begin
          // cnt indexes the byte currently on the outputs.
          if (cnt != act_last) begin
            cnt       <= cnt + 1'b1;
            lane_0_rx <= byte_at(act_pay0, cnt + 1'b1);
            lane_1_rx <= byte_at(act_pay1, cnt + 1'b1);
            rx_valid  <= 1'b1;
            rx_type   <= act_type;
            if (cap_ok) begin
              if (pend_full) begin
                overflow <= 1'b1;
              end else begin
                pend_pay0 <= in_pay0;
                pend_pay1 <= in_pay1;
                pend_last <= in_last;
                pend_type <= in_type;
                pend_full <= 1'b1;
              end
            end
          end else if (pend_full) begin
            act_pay0  <= pend_pay0;
            act_pay1  <= pend_pay1;
            act_last  <= pend_last;
            act_type  <= pend_type;
            cnt       <= '0;
            lane_0_rx <= byte_at(pend_pay0, '0);
            lane_1_rx <= byte_at(pend_pay1, '0);
            rx_valid  <= 1'b1;
            rx_type   <= pend_type;
            rx_sof    <= 1'b1;
            if (cap_ok) begin
              pend_pay0 <= in_pay0;
              pend_pay1 <= in_pay1;
              pend_last <= in_last;
              pend_type <= in_type;
            end else begin
              pend_full <= 1'b0;
            end
          end else if (cap_ok) begin
            act_pay0  <= in_pay0;
            act_pay1  <= in_pay1;
            act_last  <= in_last;
            act_type  <= in_type;
            cnt       <= '0;
            lane_0_rx <= byte_at(in_pay0, '0);
            lane_1_rx <= byte_at(in_pay1, '0);
            rx_valid  <= 1'b1;
            rx_type   <= in_type;
            rx_sof    <= 1'b1;
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoding_block.sv
// Scoreboard bench for decoding_block. The driver models the decoder as a
// byte timeline: each accepted symbol is scheduled to start at the later of
// "next cycle" and "just after the previous symbol ends"; a symbol is refused
// (overflow) when an already-accepted symbol has not yet been scheduled to
// start by next cycle. Expected bytes and pulses are queued with their cycle;
// a monitor on the falling edge pops and compares.
module tb_decoding_block;

  logic         enc_clk = 1'b0;
  logic         rst = 1'b0;
  logic         enable = 1'b0;
  logic [1:0]   gen_speed = 2'd0;
  logic         sym_valid = 1'b0;
  logic [131:0] lane_0_rx_enc = '0;
  logic [131:0] lane_1_rx_enc = '0;
  logic [7:0]   lane_0_rx, lane_1_rx;
  logic         rx_valid, rx_type, rx_sof, hdr_err, overflow;

  decoding_block #(.NUM_BYTES_G3(16), .NUM_BYTES_G2(8)) dut (
    .enc_clk(enc_clk), .rst(rst), .enable(enable), .gen_speed(gen_speed),
    .sym_valid(sym_valid), .lane_0_rx_enc(lane_0_rx_enc), .lane_1_rx_enc(lane_1_rx_enc),
    .lane_0_rx(lane_0_rx), .lane_1_rx(lane_1_rx), .rx_valid(rx_valid),
    .rx_type(rx_type), .rx_sof(rx_sof), .hdr_err(hdr_err), .overflow(overflow)
  );

  always #5 enc_clk = ~enc_clk;

  int cyc = 0;
  always @(posedge enc_clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] b0;
    logic [7:0] b1;
    logic       typ;
    logic       sof;
  } exp_t;

  exp_t exp_q[$];
  int   herr_q[$];
  int   ovf_q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_start = -100;
  int   last_end   = -100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flush(input int bound);
    while (exp_q.size() > 0 && exp_q[$].cyc >= bound) void'(exp_q.pop_back());
    while (herr_q.size() > 0 && herr_q[$] >= bound) void'(herr_q.pop_back());
    while (ovf_q.size() > 0 && ovf_q[$] >= bound) void'(ovf_q.pop_back());
    last_start = -100;
    last_end   = -100;
  endtask

  // Reference model for one strobe at cycle t.
  task automatic model(input int t, input logic [1:0] gs, input logic [3:0] h0, input logic [3:0] h1,
                       input logic [127:0] p0, input logic [127:0] p1,
                       input logic [7:0] raw0, input logic [7:0] raw1);
    bit   legal;
    bit   typ;
    int   n;
    int   start;
    exp_t e;
    if (!enable) return;
    if (gs == 2'd0) begin
      if (last_end < t) begin
        e.cyc = t + 1; e.b0 = raw0; e.b1 = raw1; e.typ = 1'b0; e.sof = 1'b1;
        exp_q.push_back(e);
      end
      return;
    end
    if (gs == 2'd3) return;
    if (gs == 2'd1) begin
      legal = (h0 == h1) && (h0 == 4'd5 || h0 == 4'd10);
      typ   = (h0 == 4'd10);
      n     = 16;
    end else begin
      legal = (h0[1:0] == h1[1:0]) && (h0[1:0] == 2'd1 || h0[1:0] == 2'd2);
      typ   = (h0[1:0] == 2'd2);
      n     = 8;
    end
    if (!legal) begin
      herr_q.push_back(t + 1);
    end else if (last_start <= t + 1) begin
      start = (t + 1 > last_end + 1) ? t + 1 : last_end + 1;
      for (int k = 0; k < n; k++) begin
        e.cyc = start + k; e.b0 = p0[8*k +: 8]; e.b1 = p1[8*k +: 8];
        e.typ = typ; e.sof = (k == 0);
        exp_q.push_back(e);
      end
      last_start = start;
      last_end   = start + n - 1;
    end else begin
      ovf_q.push_back(t + 1);
    end
  endtask

  task automatic send(input logic [1:0] gs, input logic [3:0] h0, input logic [3:0] h1,
                      input logic [127:0] p0, input logic [127:0] p1);
    logic [131:0] l0, l1;
    @(posedge enc_clk); #1;
    case (gs)
      2'd2: begin
        l0 = {$urandom, $urandom, 2'b11, p0[63:0], h0[1:0]};
        l1 = {$urandom, $urandom, 2'b10, p1[63:0], h1[1:0]};
      end
      default: begin
        l0 = {p0, h0};
        l1 = {p1, h1};
      end
    endcase
    sym_valid = 1'b1; gen_speed = gs; lane_0_rx_enc = l0; lane_1_rx_enc = l1;
    model(cyc, gs, h0, h1, p0, p1, l0[7:0], l1[7:0]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge enc_clk); #1;
      sym_valid = 1'b0;
      lane_0_rx_enc = {$urandom, $urandom, $urandom, $urandom, 4'hF};
    end
  endtask

  task automatic drop_enable();
    @(posedge enc_clk); #1;
    sym_valid = 1'b0; enable = 1'b0;
    flush(cyc + 1);
    @(posedge enc_clk); #1;
    enable = 1'b1;
  endtask

  task automatic pulse_reset();
    @(posedge enc_clk); #2;
    rst = 1'b0; sym_valid = 1'b0;
    flush(cyc);
    repeat (2) @(posedge enc_clk);
    #2 rst = 1'b1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor / scoreboard.
  always @(negedge enc_clk) begin
    exp_t e;
    int   c;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      check("byte_missing_cycle", 64'(cyc), 64'(e.cyc));
    end
    if (rx_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", rx_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("byte_cycle", 64'(cyc), 64'(e.cyc));
        check("lane_0_rx", lane_0_rx, e.b0);
        check("lane_1_rx", lane_1_rx, e.b1);
        check("rx_type", rx_type, e.typ);
        check("rx_sof", rx_sof, e.sof);
      end
    end else begin
      check("idle_outputs_zero", {lane_0_rx, lane_1_rx, rx_type, rx_sof}, 0);
    end
    while (herr_q.size() > 0 && herr_q[0] < cyc) begin
      c = herr_q.pop_front();
      check("hdr_err_missing_cycle", 64'(cyc), 64'(c));
    end
    if (hdr_err) begin
      if (herr_q.size() == 0) check("hdr_err_unexpected", hdr_err, 0);
      else begin c = herr_q.pop_front(); check("hdr_err_cycle", 64'(cyc), 64'(c)); end
    end
    while (ovf_q.size() > 0 && ovf_q[0] < cyc) begin
      c = ovf_q.pop_front();
      check("overflow_missing_cycle", 64'(cyc), 64'(c));
    end
    if (overflow) begin
      if (ovf_q.size() == 0) check("overflow_unexpected", overflow, 0);
      else begin c = ovf_q.pop_front(); check("overflow_cycle", 64'(cyc), 64'(c)); end
    end
  end

  initial begin
    logic [127:0] seq;
    logic [3:0]   h0, h1;
    logic [1:0]   gs;
    int           r;

    for (int k = 0; k < 16; k++) seq[8*k +: 8] = 8'(k);

    repeat (3) @(posedge enc_clk);
    #2 rst = 1'b1;
    @(posedge enc_clk); #1 enable = 1'b1;
    idle(2);

    // 1: single Gen3 transport symbol, bytes 0x00..0x0F.
    send(2'd1, 4'b1010, 4'b1010, seq, rnd128());
    idle(20);

    // 2: three Gen2 ordered-set symbols every 8 cycles, no gaps.
    send(2'd2, 4'b0001, 4'b0001, rnd128(), rnd128()); idle(7);
    send(2'd2, 4'b0001, 4'b0001, rnd128(), rnd128()); idle(7);
    send(2'd2, 4'b0001, 4'b0001, rnd128(), rnd128()); idle(12);

    // 3: header mismatch, then illegal header on both lanes.
    send(2'd1, 4'b0101, 4'b1010, rnd128(), rnd128()); idle(3);
    send(2'd1, 4'b1111, 4'b1111, rnd128(), rnd128()); idle(3);

    // 4: A, B, C two cycles apart; C overflows.
    send(2'd1, 4'b1010, 4'b1010, rnd128(), rnd128()); idle(1);
    send(2'd1, 4'b0101, 4'b0101, rnd128(), rnd128()); idle(1);
    send(2'd1, 4'b1010, 4'b1010, rnd128(), rnd128()); idle(36);

    // 5: enable drop at byte 5, then async reset mid-symbol.
    send(2'd1, 4'b1010, 4'b1010, seq, rnd128()); idle(5);
    drop_enable(); idle(20);
    send(2'd1, 4'b0101, 4'b0101, seq, rnd128()); idle(5);
    pulse_reset(); idle(20);

    // 6: Gen4 passthrough.
    send(2'd0, 4'h0, 4'h0, {120'h0, 8'hA5}, {120'h0, 8'h3C}); idle(3);

    // Reserved speed is ignored.
    send(2'd3, 4'b1010, 4'b1010, rnd128(), rnd128()); idle(3);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        drop_enable();
      end else if (r < 35) begin
        r  = $urandom_range(0, 19);
        gs = (r < 9) ? 2'd1 : (r < 18) ? 2'd2 : (r < 19) ? 2'd0 : 2'd3;
        if ($urandom_range(0, 99) < 85) begin
          if (gs == 2'd2) h0 = $urandom_range(0, 1) ? 4'd2 : 4'd1;
          else            h0 = $urandom_range(0, 1) ? 4'd10 : 4'd5;
          h1 = h0;
        end else begin
          h0 = 4'($urandom_range(0, 15));
          h1 = 4'($urandom_range(0, 15));
        end
        send(gs, h0, h1, rnd128(), rnd128());
      end else begin
        idle(1);
      end
    end
    idle(40);

    check("bytes_drained", 64'(exp_q.size()), 0);
    check("hdr_err_drained", 64'(herr_q.size()), 0);
    check("overflow_drained", 64'(ovf_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
